// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, lock FSM states and the pixel CRC step,
// shared by the sync receiver and the timing generator.
package vga_pkg;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_TOTAL = 525;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END = 784;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END = 515;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_LOCK_FRAMES = 2;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
    // CRC-16-CCITT (poly 0x1021) over one 12-bit {r,g,b} pixel, MSB first
    function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc, input logic [11:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: two-flop sampler with falling-edge detect for one active-low sync input.
module vga_sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic fall
);
    logic s1, s2;
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    assign fall = s2 & ~s1;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA sync receiver - line/frame measurement, lock FSM, active pixel extraction.
// Define VGA_SYNC_RX_CRC_EN to add a per-frame CRC-16-CCITT of active pixels (frame_crc, crc_valid).
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic [9:0]  px_x,
    output logic [8:0]  px_y,
    output logic [3:0]  px_r,
    output logic [3:0]  px_g,
    output logic [3:0]  px_b,
    output logic        px_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
`ifdef VGA_SYNC_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA0 = 10'(H_ACT_START);
    localparam logic [9:0] HA1 = 10'(H_ACT_END);
    localparam logic [9:0] VA0 = 10'(V_ACT_START);
    localparam logic [9:0] VA1 = 10'(V_ACT_END);
    localparam logic [7:0] LF = 8'(LOCK_FRAMES);

    logic        hfall, vfall, line_err, frame_err, e_line, e_frame, act;
    logic [11:0] c1, c2;
    logic [9:0]  hcnt, vcnt;
    logic [7:0]  gcnt, gcnt_next;
    state_t      state, st_mid, state_next;

    vga_sync_edge u_hs (.clk(clk), .clr(clr), .d(hsync_i), .fall(hfall));
    vga_sync_edge u_vs (.clk(clk), .clr(clr), .d(vsync_i), .fall(vfall));

    // colour takes the same two-flop path so c2 lines up with hcnt
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            c1 <= '0;
            c2 <= '0;
        end else begin
            c1 <= {r, g, b};
            c2 <= c1;
        end

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hfall ? '0 : (hcnt == 10'h3FF ? hcnt : hcnt + 10'd1);
            vcnt <= vfall ? '0 : ((hfall && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt);
        end

    // saturation is flagged on the step into 1023, so it fires once per event
    assign line_err  = (hfall && hcnt != H_LAST) || (!hfall && hcnt == 10'h3FE)
                     || (hfall && !vfall && vcnt == 10'h3FE);
    assign frame_err = vcnt != V_LAST;

    // line-level checks resolve before the frame check of a coincident vfall
    always_comb begin
        st_mid = state;
        e_line = 1'b0;
        if (line_err && state != SEARCH) begin
            st_mid = SEARCH;
            e_line = 1'b1;
        end
        state_next = st_mid;
        gcnt_next = gcnt;
        e_frame = 1'b0;
        if (vfall) begin
            if (st_mid == SEARCH) begin
                state_next = VERIFY;
                gcnt_next = '0;
            end else if (frame_err) begin
                state_next = SEARCH;
                e_frame = 1'b1;
            end else if (st_mid == VERIFY) begin
                gcnt_next = gcnt + 8'd1;
                state_next = (gcnt + 8'd1 == LF) ? LOCKED : VERIFY;
            end
        end
    end

    assign act = state == LOCKED && hcnt >= HA0 && hcnt < HA1 && vcnt >= VA0 && vcnt < VA1;

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state <= SEARCH;
            gcnt <= '0;
            locked <= 1'b0;
            err_cnt <= '0;
            px_valid <= 1'b0;
            frame_start <= 1'b0;
            px_x <= '0;
            px_y <= '0;
            {px_r, px_g, px_b} <= '0;
        end else begin
            state <= state_next;
            gcnt <= gcnt_next;
            locked <= state_next == LOCKED;
            err_cnt <= err_cnt + 8'((e_line || e_frame) && err_cnt != 8'hFF);
            px_valid <= act;
            frame_start <= act && hcnt == HA0 && vcnt == VA0;
            px_x <= act ? hcnt - HA0 : '0;
            px_y <= act ? 9'(vcnt - VA0) : '0;
            {px_r, px_g, px_b} <= act ? c2 : '0;
        end

`ifdef VGA_SYNC_RX_CRC_EN
    logic [15:0] crc;
    logic        last_px;
    assign last_px = act && hcnt == HA1 - 10'd1 && vcnt == VA1 - 10'd1;
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            crc <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc <= (vfall || last_px) ? 16'hFFFF : (act ? crc16_ccitt(crc, c2) : crc);
            frame_crc <= last_px ? crc16_ccitt(crc, c2) : frame_crc;
            crc_valid <= last_px;
        end
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a reduced 40x20 raster with random pixels.
// Expected pixels are queued at stimulus time from a frame-counting lock model; a monitor pops them.
module tb_vga_sync_rx;
    localparam int HT = 40, VT = 20, HAS = 10, HAE = 34, VAS = 3, VAE = 18;
    localparam int LF = 2, HSW = 4, VSW = 2;
    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [11:0] rgb; } px_t;

    logic clk = 1'b0, clr = 1'b1, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [3:0] r = '0, g = '0, b = '0;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic [3:0] px_r, px_g, px_b;
    logic px_valid, frame_start, locked;
    logic [7:0] err_cnt;
`ifdef VGA_SYNC_RX_CRC_EN
    logic [15:0] frame_crc;
    logic crc_valid;
    logic [15:0] crc_q[$];
    logic crc_bits[$];
`endif
    int total = 0, bad = 0;
    int clean = 0, err_m = 0, lines_since = 0, last_len = 0;
    px_t exp_q[$];
    px_t e;

    always #5 clk = ~clk;

    vga_sync_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
                  .V_ACT_START(VAS), .V_ACT_END(VAE), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .clr(clr), .hsync_i(hsync_i), .vsync_i(vsync_i), .r(r), .g(g), .b(b),
        .px_x(px_x), .px_y(px_y), .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .px_valid(px_valid), .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
`ifdef VGA_SYNC_RX_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

`ifdef VGA_SYNC_RX_CRC_EN
    function automatic logic [15:0] crc_of_bits();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (crc_bits[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ crc_bits[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
`endif

    // model: lock = more than LF clean vfalls since the last error or reset
    task automatic err_event();
        if (clean > 0) err_m = (err_m < 255) ? err_m + 1 : 255;
        clean = 0;
    endtask

    task automatic boundary(input int l);
        if (last_len != HT) err_event();
        if (l == 0) begin
            if (clean == 0) clean = 1;
            else if (lines_since != VT) err_event();
            else clean++;
            lines_since = 0;
`ifdef VGA_SYNC_RX_CRC_EN
            crc_bits.delete();
`endif
        end
        lines_since++;
    endtask

    task automatic drive_line(input int l, input int len, input int mode, input int clr_col);
        logic [11:0] col;
        boundary(l);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            clr = 1'b0;
            if (c == 2) begin
                chk("locked", locked, clean > LF);
                chk("err_cnt", err_cnt, err_m);
            end
            col = mode == 1 ? 12'hFFF : (mode == 2 ? 12'h000 : 12'($urandom));
            hsync_i = c >= HSW;
            vsync_i = l >= VSW;
            {r, g, b} = col;
            if (clean > LF && c >= HAS && c < HAE && l >= VAS && l < VAE) begin
                exp_q.push_back({10'(c - HAS), 9'(l - VAS), col});
`ifdef VGA_SYNC_RX_CRC_EN
                for (int i = 11; i >= 0; i--) crc_bits.push_back(col[i]);
                if (c == HAE - 1 && l == VAE - 1) crc_q.push_back(crc_of_bits());
`endif
            end
            if (c == clr_col) begin
                #2 clr = 1'b1;
                #1 chk("clr_async_zero", {px_valid, frame_start, locked, err_cnt, px_x, px_y,
                                          px_r, px_g, px_b}, 0);
                exp_q.delete();
                clean = 0;
                err_m = 0;
`ifdef VGA_SYNC_RX_CRC_EN
                crc_bits.delete();
`endif
            end
        end
        last_len = len;
    endtask

    task automatic drive_frame(input int mode, input int sp_line, input int sp_len, input int clr_line);
        for (int l = 0; l < VT; l++)
            drive_line(l, l == sp_line ? sp_len : HT, mode, l == clr_line ? 20 : -1);
    endtask

    always @(negedge clk) if (!clr) begin
        if (px_valid) begin
            chk("px_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("px_x", px_x, e.x);
                chk("px_y", px_y, e.y);
                chk("px_rgb", {px_r, px_g, px_b}, e.rgb);
                chk("frame_start", frame_start, e.x == 0 && e.y == 0);
            end
        end else chk("idle_zero", {px_x, px_y, px_r, px_g, px_b, frame_start}, 0);
`ifdef VGA_SYNC_RX_CRC_EN
        if (crc_valid) begin
            chk("crc_expected", crc_q.size() != 0, 1);
            if (crc_q.size() != 0) chk("frame_crc", frame_crc, crc_q.pop_front());
        end
`endif
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {px_valid, frame_start, px_x, px_y, px_r, px_g, px_b}, 0);
        chk("reset_locked", locked, 0);
        chk("reset_err", err_cnt, 0);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_locked", locked, 0);
        repeat (4) drive_frame(0, -1, 0, -1);
        drive_frame(1, -1, 0, -1);
        drive_frame(2, -1, 0, -1);
        drive_frame(0, 7, HT - 1, -1);
        repeat (4) drive_frame(0, -1, 0, -1);
        drive_frame(0, 5, HSW + 1100, -1);
        repeat (4) drive_frame(0, -1, 0, -1);
        chk("err_after_two_faults", err_cnt, 2);
        drive_frame(1, -1, 0, 8);
        repeat (4) drive_frame(0, -1, 0, -1);
        @(negedge clk);
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_locked", locked, 1);
        chk("final_err", err_cnt, err_m);
`ifdef VGA_SYNC_RX_CRC_EN
        chk("crc_drained", crc_q.size(), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
